// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// opcodes, ALU operation classes, ALU control codes and mux selects.
package mc_ctrl_pkg;

  // state      | meaning
  // S_FETCH    | load IR, PC <= PC + 4
  // S_DECODE   | read registers, compute branch/jump target into ALU out
  // S_MEMADR   | rs1 + imm for lw/sw
  // S_MEMREAD  | read data memory at ALU result
  // S_MEMWB    | write loaded data to rd
  // S_MEMWRITE | write rs2 to data memory
  // S_EXECR    | R-type ALU operation
  // S_EXECI    | I-type ALU operation
  // S_ALUWB    | write ALU out to rd
  // S_BEQ      | compare rs1/rs2, take branch on zero
  // S_JAL      | PC <= target, ALU computes return address
  // S_ILLEGAL  | unsupported opcode, no side effects
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_DATA       = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends on the opcode only, so it is valid even in FETCH.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// Extended ALU decoder. EXT_OPS=0 keeps the legacy op set; the extra
// funct3 codes then fall back to add.
module alu_dec_ext
  import mc_ctrl_pkg::*;
#(
  parameter bit EXT_OPS = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_5,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  // Map operation class and instruction fields to an ALU control code.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // only R-type (op[5]=1) can encode sub; addi never does
          3'b000: alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = EXT_OPS ? ALU_SLTU : ALU_ADD;
          3'b100: alu_control = EXT_OPS ? ALU_XOR : ALU_ADD;
          3'b101: begin
            if (EXT_OPS) alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
            else         alu_control = ALU_ADD;
          end
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath, with sticky
// illegal-opcode flag and retired-instruction counter.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit          EXT_OPS = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state, state_next;
  logic       pc_update, branch;
  logic       ir_write_s, mem_write_s, reg_write_s;
  logic [1:0] alu_op;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Sticky flag, raised on the edge that enters ILLEGAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       illegal <= 1'b0;
    else if (state_next == S_ILLEGAL) illegal <= 1'b1;
  end

  // An instruction retires when it returns to FETCH; aborted ones do not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instr_count <= '0;
    else if (state_next == S_FETCH && state != S_FETCH && state != S_ILLEGAL)
      instr_count <= instr_count + CNT_W'(1);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_next = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BEQ,
      S_ILLEGAL:  state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore outputs per state.
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    result_src  = RES_ALU_OUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_OP_ADD;
    case (state)
      S_FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU_RESULT;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so nothing is written while the FSM sits in
  // its reset FETCH state.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_s;
  assign mem_write = rst_n & mem_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign imm_src   = imm_src_of(op);

  alu_dec_ext #(
    .EXT_OPS (EXT_OPS)
  ) u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: an extended-ops instance and a legacy 4-bit-counter
// instance share stimulus; both are checked against an instruction-level model.
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;

  logic       m_pc_write, m_adr_src, m_mem_write, m_ir_write, m_reg_write, m_illegal;
  logic [1:0] m_result_src, m_alu_src_a, m_alu_src_b, m_imm_src;
  logic [3:0] m_alu_control;
  logic [31:0] m_count;
  logic       l_pc_write, l_adr_src, l_mem_write, l_ir_write, l_reg_write, l_illegal;
  logic [1:0] l_result_src, l_alu_src_a, l_alu_src_b, l_imm_src;
  logic [3:0] l_alu_control;
  logic [3:0] l_count;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned ref_count = 0;
  bit          ref_illegal = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller #(.EXT_OPS(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_write(m_pc_write), .adr_src(m_adr_src), .mem_write(m_mem_write),
    .ir_write(m_ir_write), .reg_write(m_reg_write), .result_src(m_result_src),
    .alu_src_a(m_alu_src_a), .alu_src_b(m_alu_src_b), .imm_src(m_imm_src),
    .alu_control(m_alu_control), .illegal(m_illegal), .instr_count(m_count)
  );

  multicycle_controller #(.EXT_OPS(1'b0), .CNT_W(4)) u_legacy (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_write(l_pc_write), .adr_src(l_adr_src), .mem_write(l_mem_write),
    .ir_write(l_ir_write), .reg_write(l_reg_write), .result_src(l_result_src),
    .alu_src_a(l_alu_src_a), .alu_src_b(l_alu_src_b), .imm_src(l_imm_src),
    .alu_control(l_alu_control), .illegal(l_illegal), .instr_count(l_count)
  );

  wire [16:0] m_bundle = {m_pc_write, m_adr_src, m_mem_write, m_ir_write, m_reg_write,
                          m_result_src, m_alu_src_a, m_alu_src_b, m_imm_src, m_alu_control};
  wire [16:0] l_bundle = {l_pc_write, l_adr_src, l_mem_write, l_ir_write, l_reg_write,
                          l_result_src, l_alu_src_a, l_alu_src_b, l_imm_src, l_alu_control};

  // Clears pc_write, mem_write, ir_write, reg_write; keeps adr_src and all selects.
  localparam logic [16:0] STROBE_OFF = 17'h08FFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit supported(input logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
  endfunction

  function automatic int cycles_of(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == SW || o == RT || o == IT || o == JL) return 4;
    return 3;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic op5,
                                         input logic f75, input bit ext);
    case (f3)
      3'd0: return (op5 && f75) ? 4'd1 : 4'd0;
      3'd1: return 4'd6;
      3'd2: return 4'd5;
      3'd3: return ext ? 4'd7 : 4'd0;
      3'd4: return ext ? 4'd4 : 4'd0;
      3'd5: return ext ? (f75 ? 4'd9 : 4'd8) : 4'd0;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Expected control outputs for cycle k (0 = fetch) of an instruction.
  function automatic logic [16:0] ref_ctrl(input logic [6:0] o, input int k,
                                           input logic [2:0] f3, input logic f75,
                                           input logic z, input bit ext);
    logic pcw = 0, adr = 0, memw = 0, irw = 0, regw = 0;
    logic [1:0] res = 0, sa = 0, sb = 0, imm;
    logic [3:0] alu = 0;
    imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
    if (k == 0) begin
      pcw = 1; irw = 1; sb = 2; res = 2;
    end else if (k == 1) begin
      sa = 1; sb = 1;
    end else if (o == LW || o == SW) begin
      if (k == 2) begin sa = 2; sb = 1; end
      else if (k == 3) begin adr = 1; memw = (o == SW); end
      else begin res = 1; regw = 1; end
    end else if (o == RT || o == IT) begin
      if (k == 2) begin sa = 2; sb = (o == IT) ? 2'd1 : 2'd0; alu = ref_alu(f3, o[5], f75, ext); end
      else regw = 1;
    end else if (o == JL) begin
      if (k == 2) begin sa = 1; sb = 2; pcw = 1; end
      else regw = 1;
    end else if (o == BQ) begin
      sa = 2; alu = 4'd1; pcw = z;
    end
    return {pcw, adr, memw, irw, regw, res, sa, sb, imm, alu};
  endfunction

  // Runs one instruction from a fetch cycle; zmode<0 randomizes zero each cycle.
  // abort_at>=0 stops before that cycle, leaving the instruction unretired.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                           input int zmode, input int abort_at);
    int n = cycles_of(o);
    op = o; funct3 = f3; funct7_5 = f75;
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) return;
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      if (k == 2 && !supported(o)) ref_illegal = 1'b1;
      check("ctrl_ext", 32'(m_bundle), 32'(ref_ctrl(o, k, f3, f75, zero, 1'b1)));
      check("ctrl_legacy", 32'(l_bundle), 32'(ref_ctrl(o, k, f3, f75, zero, 1'b0)));
      check("illegal", {30'd0, m_illegal, l_illegal}, {30'd0, ref_illegal, ref_illegal});
      @(posedge clk);
      @(negedge clk);
    end
    if (supported(o)) ref_count++;
    check("count_ext", m_count, 32'(ref_count));
    check("count_legacy", 32'(l_count), 32'(ref_count % 16));
  endtask

  task automatic hold_reset_and_release();
    rst_n = 1'b0;
    ref_count = 0;
    ref_illegal = 1'b0;
    #1;
    check("rst_ctrl", 32'(m_bundle), 32'(ref_ctrl(op, 0, funct3, funct7_5, zero, 1'b1) & STROBE_OFF));
    check("rst_count", m_count, 32'd0);
    check("rst_illegal", {31'd0, m_illegal}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    @(negedge clk);
    hold_reset_and_release();

    // Reset during MEMREAD of lw: strobes drop at once, nothing retires.
    op = LW;
    run_instr(LW, 3'd2, 1'b0, 0, 3);
    hold_reset_and_release();
    check("post_rst_count", m_count, 32'd0);

    // lw then add: 9 cycles, reg_write in cycles 5 and 9.
    run_instr(LW, 3'd2, 1'b0, 0, -1);
    run_instr(RT, 3'd0, 1'b0, 0, -1);
    check("lw_add_count", m_count, 32'd2);

    // beq taken and not taken.
    run_instr(BQ, 3'd0, 1'b0, 1, -1);
    run_instr(BQ, 3'd0, 1'b0, 0, -1);

    // sub and sra, extended vs legacy decode.
    run_instr(RT, 3'd0, 1'b1, 0, -1);
    run_instr(RT, 3'd5, 1'b1, 0, -1);
    run_instr(IT, 3'd0, 1'b1, 0, -1);

    // Illegal opcode, then a normal lw.
    run_instr(7'b1111111, 3'd0, 1'b0, 0, -1);
    run_instr(LW, 3'd2, 1'b0, 0, -1);

    // 16 R-types wrap the 4-bit counter.
    hold_reset_and_release();
    for (int i = 0; i < 16; i++) run_instr(RT, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
    check("wrap_legacy", 32'(l_count), 32'd0);
    check("wrap_ext", m_count, 32'd16);

    // Random instruction stream.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BQ;
        5: o = JL;
        default: begin
          o = 7'($urandom_range(0, 127));
          if (supported(o)) o = 7'b1111111;
        end
      endcase
      f3 = 3'($urandom_range(0, 7));
      run_instr(o, f3, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
